// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared MIPS encodings, ALU ops, instruction formats and multicycle control enums.
package cpu_types_pkg;
  localparam int WORD_W_DEF = 32;
  localparam int REGSEL_W_DEF = 5;
  localparam int LINK_REG_DEF = 31;

  typedef enum logic [5:0] {
    RTYPE = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05,
    ADDI = 6'h08, ADDIU = 6'h09, SLTI = 6'h0A, SLTIU = 6'h0B,
    ANDI = 6'h0C, ORI = 6'h0D, XORI = 6'h0E, LUI = 6'h0F,
    LW = 6'h23, SW = 6'h2B, LL = 6'h30, SC = 6'h38, HALT = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    SLL = 6'h00, SRL = 6'h02, JR = 6'h08, ADD = 6'h20, ADDU = 6'h21,
    SUB = 6'h22, SUBU = 6'h23, AND = 6'h24, OR = 6'h25, XOR = 6'h26,
    NOR = 6'h27, SLT = 6'h2A, SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef struct packed {
    opcode_t opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    funct_t funct;
  } r_t;

  typedef struct packed {
    opcode_t opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [15:0] imm;
  } i_t;

  typedef struct packed {
    opcode_t opcode;
    logic [25:0] addr;
  } j_t;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} mc_state_t;
  typedef enum logic [1:0] {NEXT, BRANCH, JUMP, JUMPREGISTER} pcsel_t;
  typedef enum logic [1:0] {PORT_O, DMEMLOAD, LUI_WORD, RTN_ADDR} wdatsel_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU_R, CL_ALU_I, CL_LW, CL_SW, CL_LL, CL_SC,
    CL_BEQ, CL_BNE, CL_J, CL_JR, CL_JAL, CL_LUI, CL_HALT
  } instr_class_t;
endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// instr_decoder: combinational IR decode into ALU controls, register selects and instruction class.
// LL/SC are recognised only when MULTICYCLE_ATOMIC_EN is defined; otherwise they decode as NOP.
module instr_decoder import cpu_types_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF,
  parameter int REGSEL_W = REGSEL_W_DEF,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic [WORD_W-1:0]   ir_i,
  output instr_class_t        cls_o,
  output aluop_t              aluop_o,
  output logic                alusrc_o,
  output logic [WORD_W-1:0]   immediate_o,
  output logic [WORD_W-1:0]   lui_word_o,
  output logic [REGSEL_W-1:0] rsel1_o,
  output logic [REGSEL_W-1:0] rsel2_o,
  output logic [REGSEL_W-1:0] wsel_o
);
  r_t r_ins;
  logic zext, shx;
  assign r_ins = r_t'(ir_i);
  always_comb begin
    cls_o = CL_NOP;
    aluop_o = ALU_ADD;
    alusrc_o = 1'b1;
    zext = 1'b0;
    shx = 1'b0;
    case (r_ins.opcode)
      RTYPE: begin
        cls_o = CL_ALU_R;
        alusrc_o = 1'b0;
        case (r_ins.funct)
          SLL: begin aluop_o = ALU_SLL; alusrc_o = 1'b1; shx = 1'b1; end
          SRL: begin aluop_o = ALU_SRL; alusrc_o = 1'b1; shx = 1'b1; end
          JR: cls_o = CL_JR;
          ADD, ADDU: aluop_o = ALU_ADD;
          SUB, SUBU: aluop_o = ALU_SUB;
          AND: aluop_o = ALU_AND;
          OR: aluop_o = ALU_OR;
          XOR: aluop_o = ALU_XOR;
          NOR: aluop_o = ALU_NOR;
          SLT: aluop_o = ALU_SLT;
          SLTU: aluop_o = ALU_SLTU;
          default: cls_o = CL_NOP;
        endcase
      end
      J: cls_o = CL_J;
      JAL: cls_o = CL_JAL;
      BEQ: begin cls_o = CL_BEQ; aluop_o = ALU_SUB; alusrc_o = 1'b0; end
      BNE: begin cls_o = CL_BNE; aluop_o = ALU_SUB; alusrc_o = 1'b0; end
      ADDI, ADDIU: cls_o = CL_ALU_I;
      SLTI: begin cls_o = CL_ALU_I; aluop_o = ALU_SLT; end
      SLTIU: begin cls_o = CL_ALU_I; aluop_o = ALU_SLTU; end
      ANDI: begin cls_o = CL_ALU_I; aluop_o = ALU_AND; zext = 1'b1; end
      ORI: begin cls_o = CL_ALU_I; aluop_o = ALU_OR; zext = 1'b1; end
      XORI: begin cls_o = CL_ALU_I; aluop_o = ALU_XOR; zext = 1'b1; end
      LUI: cls_o = CL_LUI;
      LW: cls_o = CL_LW;
      SW: cls_o = CL_SW;
`ifdef MULTICYCLE_ATOMIC_EN
      LL: cls_o = CL_LL;
      SC: cls_o = CL_SC;
`endif
      HALT: cls_o = CL_HALT;
      default: cls_o = CL_NOP;
    endcase
  end
  assign immediate_o = shx ? WORD_W'(r_ins.shamt)
                     : zext ? WORD_W'(ir_i[15:0])
                     : {{(WORD_W-16){ir_i[15]}}, ir_i[15:0]};
  assign lui_word_o = {ir_i[15:0], {(WORD_W-16){1'b0}}};
  assign rsel1_o = r_ins.rs;
  assign rsel2_o = r_ins.rt;
  assign wsel_o = cls_o == CL_ALU_R ? r_ins.rd : cls_o == CL_JAL ? REGSEL_W'(LINK_REG) : r_ins.rt;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: IF/ID/EX/MEM/WB sequencer holding IR and ALU-result registers.
// MULTICYCLE_ATOMIC_EN enables LL/SC with the datomic qualifier; otherwise datomic is tied 0.
module multicycle_control_unit import cpu_types_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF,
  parameter int REGSEL_W = REGSEL_W_DEF,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [WORD_W-1:0]   imemload,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                z_fl,
  input  logic [WORD_W-1:0]   port_o,
  input  logic [WORD_W-1:0]   rdat1,
  input  logic [WORD_W-1:0]   rdat2,
  output logic                iREN,
  output logic                dREN,
  output logic                dWEN,
  output logic                datomic,
  output logic [WORD_W-1:0]   dmemaddr,
  output logic [WORD_W-1:0]   dmemstore,
  output logic                pc_en,
  output pcsel_t              pc_select,
  output logic [WORD_W-1:0]   jump_data,
  output logic [REGSEL_W-1:0] rsel1,
  output logic [REGSEL_W-1:0] rsel2,
  output logic [REGSEL_W-1:0] wsel,
  output logic                WEN,
  output wdatsel_t            wdatsel,
  output aluop_t              aluop,
  output logic                alusrc,
  output logic [WORD_W-1:0]   immediate,
  output logic [WORD_W-1:0]   lui_word,
  output logic                mdr_en,
  output logic                cpu_halt,
  output mc_state_t           state_o
);
  mc_state_t state_q, state_d;
  logic [WORD_W-1:0] ir_q, aluout_q;
  instr_class_t cls;
  logic is_rd, is_wr;

  instr_decoder #(.WORD_W(WORD_W), .REGSEL_W(REGSEL_W), .LINK_REG(LINK_REG)) u_dec (
    .ir_i(ir_q), .cls_o(cls), .aluop_o(aluop), .alusrc_o(alusrc),
    .immediate_o(immediate), .lui_word_o(lui_word),
    .rsel1_o(rsel1), .rsel2_o(rsel2), .wsel_o(wsel)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IF;
      ir_q <= '0;
      aluout_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF && ihit) ir_q <= imemload;
      if (state_q == S_EX) aluout_q <= port_o;
    end
  end

  assign is_rd = cls == CL_LW || cls == CL_LL;
  assign is_wr = cls == CL_SW || cls == CL_SC;
  assign dmemaddr = aluout_q;
  assign dmemstore = rdat2;
  assign jump_data = cls == CL_JR ? rdat1 : ir_q;
  assign cpu_halt = state_q == S_HALT;
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    datomic = 1'b0;
    pc_en = 1'b0;
    pc_select = NEXT;
    WEN = 1'b0;
    wdatsel = PORT_O;
    mdr_en = 1'b0;
    case (state_q)
      S_IF: begin
        // state_q already reads IF while reset is held, so the fetch is gated on nRST
        iREN = nRST;
        pc_en = ihit & nRST;
        if (ihit) state_d = S_ID;
      end
      S_ID: begin
        case (cls)
          CL_J: begin pc_en = 1'b1; pc_select = JUMP; state_d = S_IF; end
          CL_JR: begin pc_en = 1'b1; pc_select = JUMPREGISTER; state_d = S_IF; end
          CL_JAL, CL_LUI: state_d = S_WB;
          CL_HALT: state_d = S_HALT;
          CL_NOP: state_d = S_IF;
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (cls)
          CL_BEQ: begin pc_en = z_fl; pc_select = BRANCH; state_d = S_IF; end
          CL_BNE: begin pc_en = !z_fl; pc_select = BRANCH; state_d = S_IF; end
          CL_LW, CL_SW, CL_LL, CL_SC: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dREN = is_rd;
        dWEN = is_wr;
`ifdef MULTICYCLE_ATOMIC_EN
        datomic = cls == CL_LL || cls == CL_SC;
`endif
        // SC latches its success flag through the MDR like a load
        if (dhit) begin
          mdr_en = is_rd || cls == CL_SC;
          state_d = cls == CL_SW ? S_IF : S_WB;
        end
      end
      S_WB: begin
        WEN = 1'b1;
        wdatsel = (is_rd || cls == CL_SC) ? DMEMLOAD
                : cls == CL_LUI ? LUI_WORD
                : cls == CL_JAL ? RTN_ADDR : PORT_O;
        pc_en = cls == CL_JAL;
        pc_select = cls == CL_JAL ? JUMP : NEXT;
        state_d = S_IF;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequenced successor to the single-cycle decoder.
- Holds the instruction register (IR) and an ALU-result register.
- Steps each MIPS instruction through a fetch/decode/execute/memory/writeback FSM, gated by the ihit/dhit memory handshakes.
- Sits between the caches and the datapath; the datapath owns the PC, register file, ALU and the MDR (loaded via mdr_en).

Parameters:
- WORD_W, 32, data/instruction word width.
- REGSEL_W, 5, register select width.
- LINK_REG, 31, register written by JAL.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- imemload  input  WORD_W  instruction from icache
- ihit  input  1  instruction fetch complete
- dhit  input  1  data access complete
- z_fl  input  1  ALU zero flag
- port_o  input  WORD_W  ALU result
- rdat1, rdat2  input  WORD_W  register file read data
- iREN  output  1  instruction read request
- dREN, dWEN  output  1  data read/write request
- datomic  output  1  atomic access qualifier
- dmemaddr  output  WORD_W  registered ALU result
- dmemstore  output  WORD_W  store data (rdat2)
- pc_en  output  1  PC load strobe
- pc_select  output  pcsel_t  NEXT/BRANCH/JUMP/JUMPREGISTER
- jump_data  output  WORD_W  IR, or rdat1 for JR
- rsel1, rsel2, wsel  output  REGSEL_W  register selects
- WEN  output  1  register write strobe
- wdatsel  output  wdatsel_t  PORT_O/DMEMLOAD/LUI_WORD/RTN_ADDR
- aluop  output  aluop_t  ALU operation
- alusrc  output  1  1 = immediate operand
- immediate  output  WORD_W  sign/zero/shamt-extended immediate
- lui_word  output  WORD_W  {IR[15:0],16'h0}
- mdr_en  output  1  datapath MDR load strobe
- cpu_halt  output  1  sticky halt
- state_o  output  mc_state_t  current state, for debug

Behaviour:
- Reset (async, nRST=0):
  - State=IF; IR=0 (decodes as SLL r0, a NOP); aluout=0.
  - All strobes (iREN, dREN, dWEN, WEN, pc_en, mdr_en, datomic, cpu_halt)=0.
  - pc_select=NEXT; wdatsel=PORT_O.
  - Reset mid-access abandons the request; no write completes.
- States: IF, ID, EX, MEM, WB, HALT.
- IF:
  - iREN=1 until ihit.
  - On ihit: IR<=imemload, pc_en=1 with NEXT (PC+4), then go to ID.
  - No ihit: stay in IF.
- ID: decode the IR; register reads become valid. Next state by type:
  - J: pc_en=1 with JUMP, go to IF.
  - JR (R-type funct JR): pc_en=1 with JUMPREGISTER, jump_data=rdat1, go to IF.
  - JAL: go to WB.
  - LUI: go to WB.
  - HALT opcode: go to HALT.
  - Unknown opcode or funct: go to IF (NOP).
  - All others: go to EX.
- EX:
  - aluop/alusrc/immediate decode as the single-cycle rules: zero-extend ANDI/ORI/XORI; shamt for SLL/SRL; sign-extend otherwise; SUB for BEQ/BNE.
  - aluout<=port_o.
  - BEQ: pc_en=1 with BRANCH iff z_fl; then IF.
  - BNE: pc_en=1 with BRANCH iff !z_fl; then IF.
  - LW/SW: go to MEM.
  - ALU ops: go to WB.
- MEM:
  - dmemaddr=aluout.
  - LW: dREN=1 held until dhit; mdr_en=1 on the dhit cycle; then WB.
  - SW: dWEN=1 held until dhit; then IF.
  - Request address and data stay stable while waiting.
- WB (single cycle, WEN=1):
  - R-type: wsel=rd, wdatsel=PORT_O (aluout).
  - I-type: wsel=rt.
  - LW: wdatsel=DMEMLOAD.
  - LUI: wdatsel=LUI_WORD.
  - JAL: wsel=LINK_REG, wdatsel=RTN_ADDR (already PC+4); pc_en=1 with JUMP the same cycle.
  - Next state IF.
- HALT: cpu_halt=1, no requests; sticky until reset.
- ihit/dhit received in a non-requesting state are ignored.
- WEN is never asserted outside WB.
- Writes to register 0 are issued; the register file discards them.
- Latency in cycles with zero-wait memory: ALU 4; LW 5; SW 4; branch 3; J/JR 2; JAL 3.

Optional Feature:
- Macro: MULTICYCLE_ATOMIC_EN.
- Defined:
  - LL takes the LW path with datomic=1 during MEM.
  - SC takes the SW path with datomic=1, then WB writes rt with wdatsel=DMEMLOAD (1 = success, 0 = fail, returned by the cache on dhit).
- Undefined: LL/SC decode as unknown (NOP); datomic is tied 0.

Decomposition:
- Extend cpu_types_pkg with:
  - enums mc_state_t, pcsel_t, wdatsel_t;
  - constant LINK_REG default.
- Reuse the existing opcode_t, funct_t, aluop_t, r_t, i_t, j_t.
- Sub-module: instr_decoder, purely combinational. IR in; aluop, alusrc, immediate, selects and instruction class out. The FSM owns all sequencing.

Test Plan:
- ORI r1,r0,0x00FF with immediate ihit -> WB on 4th cycle, WEN=1, wsel=1, immediate=0x000000FF, aluop=ALU_OR.
- LW r2,4(r1), r1=0x100, dhit delayed 3 cycles -> dREN=1 for exactly 3 cycles, dmemaddr=0x104, mdr_en pulses on the dhit cycle, WEN next cycle with wsel=2.
- BEQ: z_fl=1 -> pc_en with BRANCH in EX; z_fl=0 -> no pc_en in EX; both return to IF.
- JAL 0x40 -> WB with wsel=31, wdatsel=RTN_ADDR, pc_select=JUMP; JR r31 -> jump_data=rdat1.
- HALT -> cpu_halt=1 and iREN=0 indefinitely; nRST low mid-MEM of SW -> dWEN drops asynchronously, state_o=IF.
- With MULTICYCLE_ATOMIC_EN: SC -> dWEN=1 and datomic=1 in MEM, WB writes rt from DMEMLOAD; without the macro, SC -> no dWEN, back to IF after ID.
